seq_detector_multi: RTL and testbench
=====================================

Name: seq_detector_multi

Overview:
- Parametrised successor to the team's single-pattern Mealy serial sequence detector.
- Watches a serial bit stream and flags, in the same cycle the final bit is presented, when the last PAT_W bits match any of NUM_PAT runtime-programmable, maskable patterns.
- Adds per-pattern match flags, a lowest-index match ID, a selectable overlap/non-overlap mode, input qualification and a saturating match counter.
- Sits between a serial front end and control logic that reacts to framing or command sequences.

Parameters:
- PAT_W, 4, pattern length in bits (2..16).
- NUM_PAT, 2, number of patterns (1..8).
- CNT_W, 8, match counter width.
- PAT_INIT, {4'b1110,4'b1101}, reset value of the flattened pattern registers; pattern i occupies bits [i*PAT_W +: PAT_W].

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- x  in  1  serial data bit.
- x_valid  in  1  x is consumed this cycle only when high.
- overlap_en  in  1  1 = overlapping detection; 0 = history cleared after each match.
- cfg_we  in  1  write one pattern/mask entry.
- cfg_idx  in  $clog2(NUM_PAT) (min 1)  entry index.
- cfg_pat  in  PAT_W  pattern value; the MSB is the oldest bit.
- cfg_mask  in  PAT_W  1 = bit compared, 0 = don't-care.
- cnt_clr  in  1  clears the match counter.
- y  out  1  Mealy match output, combinational.
- match_vec  out  NUM_PAT  per-pattern match this cycle, combinational.
- match_id  out  $clog2(NUM_PAT) (min 1)  lowest matching index; 0 when y=0.
- y_q  out  1  y registered (one-cycle delay).
- match_cnt  out  CNT_W  saturating count of cycles with y=1.

Behaviour:
- Reset (reset=1 at a clock edge):
  - History and fill cleared.
  - Patterns load PAT_INIT; masks load all ones.
  - y_q=0, match_cnt=0.
  - y, match_vec and match_id are 0 while reset is high.
  - Reset mid-stream discards the partial history; detection restarts from fill=0.
- State: hist[PAT_W-1:0] holds the last bits, newest at the LSB. fill counts valid bits held (0..PAT_W-1) and saturates at PAT_W-1.
- Candidate word: cand = {hist[PAT_W-2:0], x}.
- Match condition: match_vec[i] = x_valid & (fill==PAT_W-1) & ((cand ^ pat[i]) & mask[i]) == 0.
- Outputs: y = |match_vec. match_id = the lowest i with match_vec[i]=1. These are Mealy outputs with zero latency relative to x.
- A fully-masked pattern (mask=0) matches every valid bit once fill==PAT_W-1.
- History update on a clock edge with x_valid=1:
  - If y=1 and overlap_en=0: hist<=0, fill<=0, so the matched bits are not reused.
  - Otherwise: hist<=cand, fill<=min(fill+1, PAT_W-1).
- x_valid=0: hist and fill hold, outputs 0, and gaps do not break a sequence.
- overlap_en is sampled every cycle; changing it mid-stream affects only the next match.
- Config writes:
  - cfg_we=1 writes pattern/mask[cfg_idx] at the edge; cfg_idx >= NUM_PAT is ignored.
  - The write also clears hist and fill.
  - A match evaluated in the write cycle uses the old entry.
- match_cnt:
  - Increments when y=1 and saturates at 2^CNT_W-1.
  - cnt_clr=1 sets it to 0.
  - cnt_clr and y=1 in the same cycle gives 1.
- y_q <= y every cycle.

Test Plan:
- Default patterns, reset then x=1,1,0,1 (x_valid=1) -> y=1, match_vec=01, match_id=0 during the 4th bit only; y_q=1 the next cycle; match_cnt=1.
- Default patterns, stream 1,1,1,0 -> y=1 on the 4th bit, match_vec=10, match_id=1. Stream 1,0,0,1 -> y stays 0 and match_cnt is unchanged.
- Stream 1,1,0,1,1,0,1:
  - overlap_en=1 -> y=1 on bits 4 and 7, match_cnt=2.
  - overlap_en=0 -> y=1 on bit 4 only, match_cnt=1.
- Mask and simultaneous match: write entry 1 with pat=1001, mask=1001; stream 1,1,0,1 -> match_vec=11, match_id=0, match_cnt +1. Stream 1,0,1,1 -> match_vec=10, match_id=1.
- Gaps and reset: bits 1,1 then x_valid=0 for 3 cycles, then 0,1 -> match on the final bit. Assert reset after bits 1,1,0, then send 1 -> no match; outputs and counter are 0.
- Counter: CNT_W=2, six consecutive matches in overlap mode with pattern 1111 -> match_cnt saturates at 3. cnt_clr coincident with a match -> match_cnt=1.

Source files
------------

// File: rtl/seq_detector_multi.sv
// Serial multi-pattern Mealy sequence detector with maskable, runtime-programmable
// patterns, overlap control, input qualification and a saturating match counter.
module seq_detector_multi #(
  parameter int PAT_W   = 4,
  parameter int NUM_PAT = 2,
  parameter int CNT_W   = 8,
  parameter logic [NUM_PAT*PAT_W-1:0] PAT_INIT = {4'b1110, 4'b1101},
  localparam int IDX_W  = (NUM_PAT > 1) ? $clog2(NUM_PAT) : 1,
  localparam int FILL_W = $clog2(PAT_W)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               x,
  input  logic               x_valid,
  input  logic               overlap_en,
  input  logic               cfg_we,
  input  logic [IDX_W-1:0]   cfg_idx,
  input  logic [PAT_W-1:0]   cfg_pat,
  input  logic [PAT_W-1:0]   cfg_mask,
  input  logic               cnt_clr,
  output logic               y,
  output logic [NUM_PAT-1:0] match_vec,
  output logic [IDX_W-1:0]   match_id,
  output logic               y_q,
  output logic [CNT_W-1:0]   match_cnt
);

  logic [PAT_W-1:0]  r_hist;
  logic [FILL_W-1:0] r_fill;
  logic [PAT_W-1:0]  r_pat  [NUM_PAT];
  logic [PAT_W-1:0]  r_mask [NUM_PAT];
  logic              r_y_q;
  logic [CNT_W-1:0]  r_cnt;

  logic [PAT_W-1:0]   w_cand;
  logic               w_full;
  logic [NUM_PAT-1:0] w_match_vec;
  logic [IDX_W-1:0]   w_match_id;
  logic               w_y;

  assign w_cand = {r_hist[PAT_W-2:0], x};
  assign w_full = (r_fill == FILL_W'(PAT_W - 1));

  // NOTE: every variable written in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    w_match_vec = '0;
    w_match_id  = '0;
    for (int i = 0; i < NUM_PAT; i++) begin
      w_match_vec[i] = !reset && x_valid && w_full &&
                       (((w_cand ^ r_pat[i]) & r_mask[i]) == '0);
    end
    // Walk downward so the lowest matching index is the one left standing.
    for (int i = NUM_PAT - 1; i >= 0; i--) begin
      if (w_match_vec[i]) w_match_id = IDX_W'(i);
    end
  end

  assign w_y = |w_match_vec;

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hist <= '0;
      r_fill <= '0;
      // NOTE: the pattern/mask table is a handful of config flops, not a RAM,
      // so resetting it to known defaults costs nothing and is required.
      for (int i = 0; i < NUM_PAT; i++) begin
        r_pat[i]  <= PAT_INIT[i*PAT_W +: PAT_W];
        r_mask[i] <= '1;
      end
      r_y_q <= 1'b0;
      r_cnt <= '0;
    end else begin
      if (cfg_we && (int'(cfg_idx) < NUM_PAT)) begin
        r_pat[cfg_idx]  <= cfg_pat;
        r_mask[cfg_idx] <= cfg_mask;
        r_hist          <= '0;
        r_fill          <= '0;
      end else if (x_valid) begin
        if (w_y && !overlap_en) begin
          r_hist <= '0;
          r_fill <= '0;
        end else begin
          r_hist <= w_cand;
          if (!w_full) r_fill <= r_fill + 1'b1;
        end
      end

      r_y_q <= w_y;

      // Clear wins over increment, but a match in the clear cycle still counts.
      if (cnt_clr)                 r_cnt <= CNT_W'(w_y);
      else if (w_y && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
    end
  end

  assign y         = w_y;
  assign match_vec = w_match_vec;
  assign match_id  = w_match_id;
  assign y_q       = r_y_q;
  assign match_cnt = r_cnt;

endmodule

// File: tb/tb_seq_detector_multi.sv
// Directed self-checking bench for seq_detector_multi: default and 2-bit-counter
// instances share one stimulus stream.
module tb_seq_detector_multi;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       x = 1'b0;
  logic       x_valid = 1'b0;
  logic       overlap_en = 1'b1;
  logic       cfg_we = 1'b0;
  logic [0:0] cfg_idx = '0;
  logic [3:0] cfg_pat = '0;
  logic [3:0] cfg_mask = '0;
  logic       cnt_clr = 1'b0;

  logic       y, y_q, y2, y_q2;
  logic [1:0] match_vec, match_vec2;
  logic [0:0] match_id, match_id2;
  logic [7:0] match_cnt;
  logic [1:0] match_cnt2;

  int n_checks = 0;
  int n_fail   = 0;

  seq_detector_multi u_dut (
    .clk(clk), .reset(reset), .x(x), .x_valid(x_valid), .overlap_en(overlap_en),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_pat(cfg_pat), .cfg_mask(cfg_mask),
    .cnt_clr(cnt_clr), .y(y), .match_vec(match_vec), .match_id(match_id),
    .y_q(y_q), .match_cnt(match_cnt)
  );

  seq_detector_multi #(.CNT_W(2)) u_dut_sat (
    .clk(clk), .reset(reset), .x(x), .x_valid(x_valid), .overlap_en(overlap_en),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_pat(cfg_pat), .cfg_mask(cfg_mask),
    .cnt_clr(cnt_clr), .y(y2), .match_vec(match_vec2), .match_id(match_id2),
    .y_q(y_q2), .match_cnt(match_cnt2)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; x_valid = 1'b0; cfg_we = 1'b0; cnt_clr = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic cfg_write(input logic idx, input logic [3:0] pat, input logic [3:0] mask);
    cfg_we = 1'b1; cfg_idx = idx; cfg_pat = pat; cfg_mask = mask; x_valid = 1'b0;
    step();
    cfg_we = 1'b0;
  endtask

  // Present one valid bit, check the Mealy outputs, clock it, check y_q.
  task automatic send(input string tag, input logic b, input logic [1:0] ev);
    logic [0:0] eid;
    eid = ev[0] ? 1'b0 : (ev[1] ? 1'b1 : 1'b0);
    x = b; x_valid = 1'b1;
    #1;
    check({tag, "_vec"}, 32'(match_vec), 32'(ev));
    check({tag, "_y"},   32'(y),         32'(|ev));
    check({tag, "_id"},  32'(match_id),  32'(eid));
    step();
    check({tag, "_yq"},  32'(y_q),       32'(|ev));
    x_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    do_reset();
    check("rst_y", 32'(y), 0);
    check("rst_yq", 32'(y_q), 0);
    check("rst_cnt", 32'(match_cnt), 0);

    // Pattern 0 (1101)
    overlap_en = 1'b1;
    send("p0_b1", 1'b1, 2'b00);
    send("p0_b2", 1'b1, 2'b00);
    send("p0_b3", 1'b0, 2'b00);
    send("p0_b4", 1'b1, 2'b01);
    check("p0_cnt", 32'(match_cnt), 1);

    // Pattern 1 (1110), then non-match 1001 after a non-overlap clear
    do_reset();
    overlap_en = 1'b0;
    send("p1_b1", 1'b1, 2'b00);
    send("p1_b2", 1'b1, 2'b00);
    send("p1_b3", 1'b1, 2'b00);
    send("p1_b4", 1'b0, 2'b10);
    send("nm_b1", 1'b1, 2'b00);
    send("nm_b2", 1'b0, 2'b00);
    send("nm_b3", 1'b0, 2'b00);
    send("nm_b4", 1'b1, 2'b00);
    check("nm_cnt", 32'(match_cnt), 1);

    // Overlapping stream 1101101
    do_reset();
    overlap_en = 1'b1;
    send("ov_b1", 1'b1, 2'b00);
    send("ov_b2", 1'b1, 2'b00);
    send("ov_b3", 1'b0, 2'b00);
    send("ov_b4", 1'b1, 2'b01);
    send("ov_b5", 1'b1, 2'b00);
    send("ov_b6", 1'b0, 2'b00);
    send("ov_b7", 1'b1, 2'b01);
    check("ov_cnt", 32'(match_cnt), 2);

    // Same stream, non-overlapping
    do_reset();
    overlap_en = 1'b0;
    send("no_b1", 1'b1, 2'b00);
    send("no_b2", 1'b1, 2'b00);
    send("no_b3", 1'b0, 2'b00);
    send("no_b4", 1'b1, 2'b01);
    send("no_b5", 1'b1, 2'b00);
    send("no_b6", 1'b0, 2'b00);
    send("no_b7", 1'b1, 2'b00);
    check("no_cnt", 32'(match_cnt), 1);

    // Masked entry 1: pat 1001, mask 1001 -> only bits 3 and 0 compared
    do_reset();
    overlap_en = 1'b0;
    cfg_write(1'b1, 4'b1001, 4'b1001);
    send("mk_b1", 1'b1, 2'b00);
    send("mk_b2", 1'b1, 2'b00);
    send("mk_b3", 1'b0, 2'b00);
    send("mk_b4", 1'b1, 2'b11);
    check("mk_cnt1", 32'(match_cnt), 1);
    send("mk_b5", 1'b1, 2'b00);
    send("mk_b6", 1'b0, 2'b00);
    send("mk_b7", 1'b1, 2'b00);
    send("mk_b8", 1'b1, 2'b10);
    check("mk_cnt2", 32'(match_cnt), 2);

    // Gaps: x held at 1 while invalid must not enter the history
    do_reset();
    overlap_en = 1'b1;
    send("gp_b1", 1'b1, 2'b00);
    send("gp_b2", 1'b1, 2'b00);
    x = 1'b1; x_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("gp_idle_y", 32'(y), 0);
      step();
    end
    send("gp_b3", 1'b0, 2'b00);
    send("gp_b4", 1'b1, 2'b01);

    // Reset mid-stream: outputs gated during reset, history discarded
    do_reset();
    send("rm_b1", 1'b1, 2'b00);
    send("rm_b2", 1'b1, 2'b00);
    send("rm_b3", 1'b0, 2'b00);
    reset = 1'b1; x = 1'b1; x_valid = 1'b1;
    #1;
    check("rm_rst_y", 32'(y), 0);
    check("rm_rst_vec", 32'(match_vec), 0);
    check("rm_rst_id", 32'(match_id), 0);
    step();
    reset = 1'b0; x_valid = 1'b0;
    send("rm_b4", 1'b1, 2'b00);
    check("rm_cnt", 32'(match_cnt), 0);

    // Counter saturation with pattern 1111 in overlap mode
    do_reset();
    overlap_en = 1'b1;
    cfg_write(1'b0, 4'b1111, 4'b1111);
    for (int i = 0; i < 9; i++) send("sat", 1'b1, (i >= 3) ? 2'b01 : 2'b00);
    check("sat_cnt2", 32'(match_cnt2), 3);
    check("sat_cnt8", 32'(match_cnt), 6);

    // Clear coincident with a match leaves one
    cnt_clr = 1'b1;
    send("clr", 1'b1, 2'b01);
    cnt_clr = 1'b0;
    check("clr_cnt8", 32'(match_cnt), 1);
    check("clr_cnt2", 32'(match_cnt2), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
